axi_mem_responder: RTL

- AXI-Lite-style memory responder. It is the slave end of the DMA core's memory master interface: it accepts DMA read/write requests and returns data and write responses.
- Word-addressed internal memory with parameterised wait states. Used in the SoC testbench and in FPGA bring-up in place of external memory.
- Read and write channels run independently; each has one outstanding transaction.

---
 rtl/axi_mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 33 +++
 rtl/axi_mem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types, widths and address helper for the AXI-Lite memory responder.
package axi_mem_pkg;

    localparam int unsigned LAT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

    // Byte address to word index; upper bits fold back modulo depth (depth is a power of two).
    function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 2) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-clock 1R1W word memory with registered read; storage is never reset.
module mem_array
    import axi_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Registered read; a write on the same edge is not visible (old data returned).
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-Lite-style memory slave: independent read and write channels, one
// outstanding transaction each, with programmable wait states.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    rd_state_e         rd_state, rd_next;
    logic [LAT_W-1:0]  rd_cnt, rd_cnt_d;
    logic [AW-1:0]     rd_idx, rd_idx_d;
    logic [AW-1:0]     ar_idx;
    logic              rd_en;
    logic [DATA_W-1:0] rd_q;

    wr_state_e         wr_state, wr_next;
    logic [LAT_W-1:0]  wr_cnt, wr_cnt_d;
    logic              aw_held, aw_held_d;
    logic              w_held, w_held_d;
    logic [AW-1:0]     wr_idx, wr_idx_d;
    logic [DATA_W-1:0] wr_data, wr_data_d;
    logic              wr_en;

    assign ar_idx = AW'(idx_of(axi_araddr, DEPTH_WORDS));

    // Memory is read on the edge entering R_DATA and written on the edge entering W_RESP.
    assign rd_en = (rd_state != R_DATA) && (rd_next == R_DATA);
    assign wr_en = (wr_state != W_RESP) && (wr_next == W_RESP);

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_idx_d),
        .rd_data (rd_q),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (wr_data)
    );

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            rd_idx   <= '0;
        end else begin
            rd_state <= rd_next;
            rd_cnt   <= rd_cnt_d;
            rd_idx   <= rd_idx_d;
        end
    end

    // Read FSM next state: accept AR, count wait states, hold data until accepted.
    always_comb begin
        rd_next  = rd_state;
        rd_cnt_d = rd_cnt;
        rd_idx_d = rd_idx;
        case (rd_state)
            R_IDLE: begin
                if (axi_arvalid && axi_arready) begin
                    rd_idx_d = ar_idx;
                    if (RD_LATENCY == 0) begin
                        rd_next = R_DATA;
                    end else begin
                        rd_next  = R_WAIT;
                        rd_cnt_d = LAT_W'(RD_LATENCY - 1);
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt == '0) begin
                    rd_next = R_DATA;
                end else begin
                    rd_cnt_d = rd_cnt - LAT_W'(1);
                end
            end
            R_DATA: begin
                if (axi_rvalid && axi_rready) begin
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read channel outputs; rvalid rises one cycle after the memory sample and rdata then holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_arready <= 1'b1;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
        end else begin
            axi_arready <= (rd_next == R_IDLE);
            axi_rvalid  <= (rd_state == R_DATA) && (rd_next == R_DATA);
            if ((rd_state == R_DATA) && !axi_rvalid) begin
                axi_rdata <= rd_q;
            end
        end
    end

    // Write FSM state register and held AW/W payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
        end else begin
            wr_state <= wr_next;
            wr_cnt   <= wr_cnt_d;
            aw_held  <= aw_held_d;
            w_held   <= w_held_d;
            wr_idx   <= wr_idx_d;
            wr_data  <= wr_data_d;
        end
    end

    // Write FSM next state: capture AW and W in any order, wait, then respond.
    always_comb begin
        wr_next   = wr_state;
        wr_cnt_d  = wr_cnt;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        wr_idx_d  = wr_idx;
        wr_data_d = wr_data;
        case (wr_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    if (WR_LATENCY == 0) begin
                        wr_next = W_RESP;
                    end else begin
                        wr_next  = W_WAIT;
                        wr_cnt_d = LAT_W'(WR_LATENCY - 1);
                    end
                end else begin
                    if (axi_awvalid && axi_awready) begin
                        aw_held_d = 1'b1;
                        wr_idx_d  = AW'(idx_of(axi_awaddr, DEPTH_WORDS));
                    end
                    if (axi_wvalid && axi_wready) begin
                        w_held_d  = 1'b1;
                        wr_data_d = axi_wdata;
                    end
                end
            end
            W_WAIT: begin
                if (wr_cnt == '0) begin
                    wr_next = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt - LAT_W'(1);
                end
            end
            W_RESP: begin
                if (axi_bvalid && axi_bready) begin
                    wr_next   = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write channel outputs, registered from the next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            axi_bvalid  <= 1'b0;
        end else begin
            axi_awready <= (wr_next == W_IDLE) && !aw_held_d;
            axi_wready  <= (wr_next == W_IDLE) && !w_held_d;
            axi_bvalid  <= (wr_next == W_RESP);
        end
    end

endmodule
